alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU with a valid/ready request port and a held,
// registered result port.
//
// Single-cycle ops (logic, add/sub/inc/dec, shifts, SLT) are computed
// combinationally from the request inputs and registered on the accepting
// edge. MUL runs an iterative shift-add over WIDTH cycles.
// Every result is held in DONE until the consumer takes it.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous, active-high reset
//   in_valid      request valid
//   in_ready      request can be accepted (high only in IDLE)
//   alu_op1       first operand
//   alu_op2       second operand; low log2(WIDTH) bits are the shift amount
//   alu_control   operation select (0..12; 13..15 give 0)
//   out_valid     result valid (high only in DONE)
//   out_ready     consumer accepts the result
//   alu_result    registered result
//   alu_zero / alu_negative / alu_carry / alu_overflow   registered flags
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_op1,
    input  logic [WIDTH-1:0] alu_op2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_zero,
    output logic             alu_negative,
    output logic             alu_carry,
    output logic             alu_overflow
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_NOT = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_INC = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [3:0] OP_SLT = 4'd12;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // result plus flags, registered as one unit
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             negative;
        logic             carry;
        logic             overflow;
    } resp_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Single-cycle datapath, driven straight from the request inputs so
    // the answer can be registered on the accepting edge.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] addend;
    logic             is_sub;
    logic             is_arith;
    logic [WIDTH:0]   sum_ext;
    logic [SHW-1:0]   shamt;
    logic             slt_lt;
    logic [WIDTH-1:0] comb_res;
    logic             comb_carry;
    logic             comb_ovf;
    resp_t            comb_resp;

    assign shamt  = alu_op2[SHW-1:0];
    assign slt_lt = $signed(alu_op1) < $signed(alu_op2);

    // INC/DEC reuse the ADD/SUB adder with a constant 1 as the addend.
    always_comb begin
        addend   = alu_op2;
        is_sub   = 1'b0;
        is_arith = 1'b0;
        case (alu_control)
            OP_ADD: begin addend = alu_op2; is_arith = 1'b1; end
            OP_SUB: begin addend = alu_op2; is_sub = 1'b1; is_arith = 1'b1; end
            OP_INC: begin addend = ONE;     is_arith = 1'b1; end
            OP_DEC: begin addend = ONE;     is_sub = 1'b1; is_arith = 1'b1; end
            default: ;
        endcase
    end

    // With a zero-extended subtract, bit WIDTH of the difference is the
    // unsigned borrow (op1 < subtrahend); for add it is the carry-out.
    assign sum_ext = is_sub ? ({1'b0, alu_op1} - {1'b0, addend})
                            : ({1'b0, alu_op1} + {1'b0, addend});

    always_comb begin
        comb_carry = 1'b0;
        comb_ovf   = 1'b0;
        if (is_arith) begin
            comb_carry = sum_ext[WIDTH];
            // Overflow: add of like signs, or subtract of unlike signs,
            // whose result sign differs from op1.
            if (is_sub)
                comb_ovf = (alu_op1[WIDTH-1] != addend[WIDTH-1]) &&
                           (sum_ext[WIDTH-1] != alu_op1[WIDTH-1]);
            else
                comb_ovf = (alu_op1[WIDTH-1] == addend[WIDTH-1]) &&
                           (sum_ext[WIDTH-1] != alu_op1[WIDTH-1]);
        end
    end

    always_comb begin
        comb_res = '0;
        case (alu_control)
            OP_NOT: comb_res = ~alu_op1;
            OP_AND: comb_res = alu_op1 & alu_op2;
            OP_XOR: comb_res = alu_op1 ^ alu_op2;
            OP_OR:  comb_res = alu_op1 | alu_op2;
            OP_DEC,
            OP_ADD,
            OP_SUB,
            OP_INC: comb_res = sum_ext[WIDTH-1:0];
            OP_SLL: comb_res = alu_op1 << shamt;
            OP_SRL: comb_res = alu_op1 >> shamt;
            OP_SRA: comb_res = $unsigned($signed(alu_op1) >>> shamt);
            OP_SLT: comb_res = {{(WIDTH-1){1'b0}}, slt_lt};
            default: comb_res = '0;   // MUL is handled iteratively; 13..15 -> 0
        endcase
    end

    assign comb_resp = '{result:   comb_res,
                         zero:     (comb_res == '0),
                         negative: comb_res[WIDTH-1],
                         carry:    comb_carry,
                         overflow: comb_ovf};

    // ------------------------------------------------------------------
    // Iterative multiplier: one multiplier bit per cycle. The multiplicand
    // shifts left and the multiplier right so bit 0 always selects.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] mul_step;
    logic             mul_last;
    resp_t            mul_resp;

    assign mul_step = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (cnt == CNT_LAST);
    assign mul_resp = '{result:   mul_step,
                        zero:     (mul_step == '0),
                        negative: mul_step[WIDTH-1],
                        carry:    1'b0,
                        overflow: 1'b0};

    logic accept;
    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)
                        state_nxt = (alu_control == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (mul_last) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath registers. Inputs are only looked at on the accepting edge,
    // so operand changes while busy have no effect.
    // ------------------------------------------------------------------
    resp_t resp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (alu_control == OP_MUL) begin
                            mcand  <= alu_op1;
                            mplier <= alu_op2;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            resp_q <= comb_resp;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mul_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (mul_last) resp_q <= mul_resp;
                end
                default: ;   // DONE holds the result until it is taken
            endcase
        end
    end

    assign alu_result   = resp_q.result;
    assign alu_zero     = resp_q.zero;
    assign alu_negative = resp_q.negative;
    assign alu_carry    = resp_q.carry;
    assign alu_overflow = resp_q.overflow;

endmodule
